// File: rtl/gates_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// gates_seq_ctrl_if
//   Bundles the control, stimulus, response and result signals exchanged
//   around the gates self-test sequencer.
//   slave  : the sequencer side (gates_seq_ctrl)
//   master : the system controller / gates side that talks to the sequencer
// Signals:
//   iStart, iAbort            run control into the sequencer
//   oA, oB                    stimulus towards the gates iA/iB
//   iAND..iNAND2              gate responses back into the sequencer
//   oBusy, oDone, oPass       run status
//   oFailVec, oFailIdx        mismatch map and first failing vector
//   oVecIdx                   vector currently applied
//   oErrCnt                   failing-vector count (GATES_SEQ_ERRCNT_EN only)
// Optional feature macro: GATES_SEQ_ERRCNT_EN
// ---------------------------------------------------------------------------
interface gates_seq_ctrl_if;
    logic       iStart;
    logic       iAbort;
    logic       oA;
    logic       oB;
    logic       iAND;
    logic       iOR;
    logic       iNOT;
    logic       iNAND;
    logic       iNAND2;
    logic       oBusy;
    logic       oDone;
    logic       oPass;
    logic [4:0] oFailVec;
    logic [1:0] oFailIdx;
    logic [1:0] oVecIdx;
`ifdef GATES_SEQ_ERRCNT_EN
    logic [2:0] oErrCnt;
`endif

    modport slave (
`ifdef GATES_SEQ_ERRCNT_EN
        output oErrCnt,
`endif
        input  iStart, iAbort, iAND, iOR, iNOT, iNAND, iNAND2,
        output oA, oB, oBusy, oDone, oPass, oFailVec, oFailIdx, oVecIdx
    );

    modport master (
`ifdef GATES_SEQ_ERRCNT_EN
        input  oErrCnt,
`endif
        output iStart, iAbort, iAND, iOR, iNOT, iNAND, iNAND2,
        input  oA, oB, oBusy, oDone, oPass, oFailVec, oFailIdx, oVecIdx
    );
endinterface

// File: rtl/gates_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gates_seq_ctrl
//   Self-test sequencer for the two-input gates datapath. Walks oA/oB through
//   00, 01, 10, 11, holds each vector for SETTLE_CYC cycles, then checks the
//   AND/OR/NOT/NAND/NAND2 responses in one CHECK cycle. Reports pass/fail,
//   a sticky mismatch map and the first failing vector index.
// Ports:
//   iClk   : system clock, rising edge
//   iRsn   : asynchronous active-low reset
//   bus    : gates_seq_ctrl_if.slave (control, stimulus, responses, results)
// Parameters:
//   SETTLE_CYC : hold cycles per vector before checking (>=1)
// Optional feature macro: GATES_SEQ_ERRCNT_EN
//   defined   : all four vectors always run, oErrCnt counts failing vectors
//   undefined : the first failing CHECK ends the run early, no oErrCnt
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module gates_seq_ctrl #(
    parameter int SETTLE_CYC = 4
) (
    input  logic             iClk,
    input  logic             iRsn,
    gates_seq_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Expected gate responses for stimulus (a,b), packed like oFailVec.
    function automatic logic [4:0] expectedOut(input logic a, input logic b);
        logic [4:0] e;
        e[0] = a & b;
        e[1] = a | b;
        e[2] = ~a;
        e[3] = ~(a & b);
        e[4] = ~(a & b);
        return e;
    endfunction

    state_t           stateR,   stateNxtS;
    logic [CNT_W-1:0] cntR,     cntNxtS;
    logic [1:0]       vecIdxR,  vecIdxNxtS;
    logic             busyR,    busyNxtS;
    logic             doneR,    doneNxtS;
    logic             passR,    passNxtS;
    logic [4:0]       failVecR, failVecNxtS;
    logic [1:0]       failIdxR, failIdxNxtS;
    logic [4:0]       mismatchS;
`ifdef GATES_SEQ_ERRCNT_EN
    logic [2:0]       errCntR,  errCntNxtS;
`endif

    // Per-gate mismatch of the responses against the vector on oA/oB.
    always_comb begin
        mismatchS = {bus.iNAND2, bus.iNAND, bus.iNOT, bus.iOR, bus.iAND}
                    ^ expectedOut(vecIdxR[1], vecIdxR[0]);
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        stateNxtS   = stateR;
        cntNxtS     = cntR;
        vecIdxNxtS  = vecIdxR;
        doneNxtS    = 1'b0;
        passNxtS    = passR;
        failVecNxtS = failVecR;
        failIdxNxtS = failIdxR;
`ifdef GATES_SEQ_ERRCNT_EN
        errCntNxtS  = errCntR;
`endif

        case (stateR)
            IDLE: begin
                vecIdxNxtS = 2'd0;
                // Abort wins over start even while idle.
                if (bus.iStart && !bus.iAbort) begin
                    stateNxtS   = SETTLE;
                    cntNxtS     = CNT_LOAD;
                    passNxtS    = 1'b0;
                    failVecNxtS = 5'd0;
                    failIdxNxtS = 2'd0;
`ifdef GATES_SEQ_ERRCNT_EN
                    errCntNxtS  = 3'd0;
`endif
                end else begin
                    stateNxtS = IDLE;
                end
            end

            SETTLE: begin
                if (cntR == {CNT_W{1'b0}}) begin
                    stateNxtS = CHECK;
                end else begin
                    cntNxtS = cntR - CNT_W'(1);
                end
            end

            CHECK: begin
                failVecNxtS = failVecR | mismatchS;
                // Only the first failing vector is recorded; a clean map so
                // far means this is the first one.
                if ((mismatchS != 5'd0) && (failVecR == 5'd0)) begin
                    failIdxNxtS = vecIdxR;
                end else begin
                    failIdxNxtS = failIdxR;
                end
`ifdef GATES_SEQ_ERRCNT_EN
                errCntNxtS = errCntR + {2'b00, |mismatchS};
                if (vecIdxR == 2'd3) begin
`else
                if ((vecIdxR == 2'd3) || (mismatchS != 5'd0)) begin
`endif
                    stateNxtS = DONE;
                    doneNxtS  = 1'b1;
                    passNxtS  = (failVecNxtS == 5'd0);
                end else begin
                    stateNxtS  = SETTLE;
                    vecIdxNxtS = vecIdxR + 2'd1;
                    cntNxtS    = CNT_LOAD;
                end
            end

            DONE: begin
                stateNxtS  = IDLE;
                vecIdxNxtS = 2'd0;
            end

            default: begin
                stateNxtS  = IDLE;
                vecIdxNxtS = 2'd0;
                cntNxtS    = {CNT_W{1'b0}};
            end
        endcase

        // Abort drops the run from any active state; the fail map and index
        // keep whatever was accumulated before this cycle.
        if ((stateR != IDLE) && bus.iAbort) begin
            stateNxtS   = IDLE;
            vecIdxNxtS  = 2'd0;
            cntNxtS     = {CNT_W{1'b0}};
            doneNxtS    = 1'b0;
            passNxtS    = 1'b0;
            failVecNxtS = failVecR;
            failIdxNxtS = failIdxR;
`ifdef GATES_SEQ_ERRCNT_EN
            errCntNxtS  = errCntR;
`endif
        end else begin
            stateNxtS = stateNxtS;
        end

        busyNxtS = (stateNxtS != IDLE);
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            stateR   <= IDLE;
            cntR     <= {CNT_W{1'b0}};
            vecIdxR  <= 2'd0;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            passR    <= 1'b0;
            failVecR <= 5'd0;
            failIdxR <= 2'd0;
`ifdef GATES_SEQ_ERRCNT_EN
            errCntR  <= 3'd0;
`endif
        end else begin
            stateR   <= stateNxtS;
            cntR     <= cntNxtS;
            vecIdxR  <= vecIdxNxtS;
            busyR    <= busyNxtS;
            doneR    <= doneNxtS;
            passR    <= passNxtS;
            failVecR <= failVecNxtS;
            failIdxR <= failIdxNxtS;
`ifdef GATES_SEQ_ERRCNT_EN
            errCntR  <= errCntNxtS;
`endif
        end
    end

    // The vector index register doubles as the stimulus: k = {oA, oB}.
    assign bus.oA       = vecIdxR[1];
    assign bus.oB       = vecIdxR[0];
    assign bus.oVecIdx  = vecIdxR;
    assign bus.oBusy    = busyR;
    assign bus.oDone    = doneR;
    assign bus.oPass    = passR;
    assign bus.oFailVec = failVecR;
    assign bus.oFailIdx = failIdxR;
`ifdef GATES_SEQ_ERRCNT_EN
    assign bus.oErrCnt  = errCntR;
`endif

endmodule

// File: tb/tb_gates_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gates_seq_ctrl
//   Directed bench for gates_seq_ctrl (SETTLE_CYC = 4). A behavioural gates
//   model with per-output stuck-at overrides answers the sequencer. A table
//   of fault cases gives the hand-computed latency and results for each run;
//   reset, abort, start-while-busy and start+abort are separate sequences.
// ---------------------------------------------------------------------------
module tb_gates_seq_ctrl;

    logic iClk = 1'b0;
    logic iRsn = 1'b0;

    gates_seq_ctrl_if busIf ();

    gates_seq_ctrl #(.SETTLE_CYC(4)) dut (
        .iClk (iClk),
        .iRsn (iRsn),
        .bus  (busIf)
    );

    always #5 iClk = ~iClk;

    // Gates model: true function, with masked bits forced to a stuck value.
    logic [4:0] faultMask = 5'd0;
    logic [4:0] faultVal  = 5'd0;
    logic [4:0] trueS;
    logic [4:0] gateS;
    always_comb begin
        trueS[0] = busIf.oA & busIf.oB;
        trueS[1] = busIf.oA | busIf.oB;
        trueS[2] = ~busIf.oA;
        trueS[3] = ~(busIf.oA & busIf.oB);
        trueS[4] = ~(busIf.oA & busIf.oB);
        gateS    = (trueS & ~faultMask) | (faultVal & faultMask);
    end
    assign busIf.iAND   = gateS[0];
    assign busIf.iOR    = gateS[1];
    assign busIf.iNOT   = gateS[2];
    assign busIf.iNAND  = gateS[3];
    assign busIf.iNAND2 = gateS[4];

    typedef struct {
        logic [4:0] mask;
        logic [4:0] val;
        int         lat;
        logic       pass;
        logic [4:0] fv;
        logic [1:0] fi;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl [8];
    int   nVec = 0;
    int   nMis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full run of table entry i; pokeAt >= 0 re-asserts iStart mid-run.
    task automatic runVec(input int i, input int pokeAt);
        int         e;
        logic       seqOk;
        logic [1:0] v;
        faultMask = tbl[i].mask;
        faultVal  = tbl[i].val;
        @(negedge iClk);
        busIf.iStart = 1'b1;
        @(negedge iClk);
        busIf.iStart = 1'b0;
        e     = 0;
        seqOk = 1'b1;
        while (busIf.oDone !== 1'b1 && e < 200) begin
            v = 2'(e / 5);
            if (!(busIf.oBusy === 1'b1 && busIf.oVecIdx === v &&
                  busIf.oA === v[1] && busIf.oB === v[0])) seqOk = 1'b0;
            busIf.iStart = (e == pokeAt) ? 1'b1 : 1'b0;
            @(negedge iClk);
            e++;
        end
        busIf.iStart = 1'b0;
        chk($sformatf("run%0d stimulus sequence", i), {31'd0, seqOk}, 32'd1);
        chk($sformatf("run%0d done latency", i), 32'(e), 32'(tbl[i].lat));
        chk($sformatf("run%0d pass", i), {31'd0, busIf.oPass}, {31'd0, tbl[i].pass});
        chk($sformatf("run%0d failVec", i), {27'd0, busIf.oFailVec}, {27'd0, tbl[i].fv});
        chk($sformatf("run%0d failIdx", i), {30'd0, busIf.oFailIdx}, {30'd0, tbl[i].fi});
`ifdef GATES_SEQ_ERRCNT_EN
        chk($sformatf("run%0d errCnt", i), {29'd0, busIf.oErrCnt}, {29'd0, tbl[i].ec});
`endif
        @(negedge iClk);
        chk($sformatf("run%0d done/busy after", i),
            {30'd0, busIf.oDone, busIf.oBusy}, 32'd0);
        chk($sformatf("run%0d pass held", i), {31'd0, busIf.oPass}, {31'd0, tbl[i].pass});
    endtask

    initial begin
        int   e;
        logic sawDone;

        // mask, val, latency, pass, failVec, failIdx, errCnt
`ifdef GATES_SEQ_ERRCNT_EN
        tbl[0] = '{5'b00000, 5'b00000, 20, 1'b1, 5'b00000, 2'd0, 3'd0};
        tbl[1] = '{5'b10000, 5'b00000, 20, 1'b0, 5'b10000, 2'd0, 3'd3};
        tbl[2] = '{5'b00000, 5'b00000, 20, 1'b1, 5'b00000, 2'd0, 3'd0};
        tbl[3] = '{5'b00001, 5'b00001, 20, 1'b0, 5'b00001, 2'd0, 3'd3};
        tbl[4] = '{5'b00010, 5'b00000, 20, 1'b0, 5'b00010, 2'd1, 3'd3};
        tbl[5] = '{5'b00100, 5'b00100, 20, 1'b0, 5'b00100, 2'd2, 3'd2};
        tbl[6] = '{5'b00001, 5'b00000, 20, 1'b0, 5'b00001, 2'd3, 3'd1};
        tbl[7] = '{5'b01100, 5'b01000, 20, 1'b0, 5'b01100, 2'd0, 3'd3};
`else
        tbl[0] = '{5'b00000, 5'b00000, 20, 1'b1, 5'b00000, 2'd0, 3'd0};
        tbl[1] = '{5'b10000, 5'b00000,  5, 1'b0, 5'b10000, 2'd0, 3'd0};
        tbl[2] = '{5'b00000, 5'b00000, 20, 1'b1, 5'b00000, 2'd0, 3'd0};
        tbl[3] = '{5'b00001, 5'b00001,  5, 1'b0, 5'b00001, 2'd0, 3'd0};
        tbl[4] = '{5'b00010, 5'b00000, 10, 1'b0, 5'b00010, 2'd1, 3'd0};
        tbl[5] = '{5'b00100, 5'b00100, 15, 1'b0, 5'b00100, 2'd2, 3'd0};
        tbl[6] = '{5'b00001, 5'b00000, 20, 1'b0, 5'b00001, 2'd3, 3'd0};
        tbl[7] = '{5'b01100, 5'b01000,  5, 1'b0, 5'b00100, 2'd0, 3'd0};
`endif

        busIf.iStart = 1'b0;
        busIf.iAbort = 1'b0;

        // Reset state.
        #12;
        chk("reset outputs",
            {13'd0, busIf.oA, busIf.oB, busIf.oBusy, busIf.oDone, busIf.oPass,
             busIf.oFailVec, busIf.oFailIdx, busIf.oVecIdx, 5'd0}, 32'd0);
        @(negedge iClk);
        iRsn = 1'b1;

        // Reset mid-run, in vector 2 SETTLE.
        @(negedge iClk);
        busIf.iStart = 1'b1;
        @(negedge iClk);
        busIf.iStart = 1'b0;
        repeat (11) @(negedge iClk);
        chk("midrun busy/vec", {29'd0, busIf.oBusy, busIf.oVecIdx}, 32'd6);
        #2 iRsn = 1'b0;
        #1;
        chk("async reset outputs",
            {13'd0, busIf.oA, busIf.oB, busIf.oBusy, busIf.oDone, busIf.oPass,
             busIf.oFailVec, busIf.oFailIdx, busIf.oVecIdx, 5'd0}, 32'd0);
        @(negedge iClk);
        iRsn = 1'b1;
        repeat (2) @(negedge iClk);
        chk("idle after reset", {31'd0, busIf.oBusy}, 32'd0);

        // Table runs: includes a faulty run followed by a good one.
        for (int i = 0; i < 8; i++) runVec(i, -1);

        // iStart while busy is ignored.
        runVec(0, 7);

        // Abort during vector 2 SETTLE after a passing run.
        @(negedge iClk);
        busIf.iStart = 1'b1;
        @(negedge iClk);
        busIf.iStart = 1'b0;
        repeat (11) @(negedge iClk);
        chk("abort pre busy/vec", {29'd0, busIf.oBusy, busIf.oVecIdx}, 32'd6);
        busIf.iAbort = 1'b1;
        @(negedge iClk);
        busIf.iAbort = 1'b0;
        chk("abort busy/oA/oB", {29'd0, busIf.oBusy, busIf.oA, busIf.oB}, 32'd0);
        chk("abort pass", {31'd0, busIf.oPass}, 32'd0);
        chk("abort failVec", {27'd0, busIf.oFailVec}, 32'd0);
        sawDone = 1'b0;
        for (e = 0; e < 25; e++) begin
            if (busIf.oDone === 1'b1 || busIf.oBusy === 1'b1) sawDone = 1'b1;
            @(negedge iClk);
        end
        chk("abort no done/busy", {31'd0, sawDone}, 32'd0);

        // iStart and iAbort together while idle.
        busIf.iStart = 1'b1;
        busIf.iAbort = 1'b1;
        @(negedge iClk);
        chk("start+abort idle", {31'd0, busIf.oBusy}, 32'd0);
        busIf.iStart = 1'b0;
        busIf.iAbort = 1'b0;
        @(negedge iClk);
        chk("start+abort stays idle", {30'd0, busIf.oBusy, busIf.oDone}, 32'd0);

        // A normal run after all of the above.
        runVec(2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
